seq_count_3b_monitor: RTL and testbench
=======================================

Name: seq_count_3b_monitor

Overview:
- Downstream checker for the 3-bit binary up counter.
- Samples the counter's output stream and verifies that every valid sample equals the previous sample + 1 (mod 8).
- Reports lock status, single-cycle error and wrap pulses, and saturating error and wrap tallies for debug and status registers.
- Sits directly on the counter's `out` bus, qualified by a valid strobe.

Parameters:
- CNT_W, 3: width of monitored count; wrap is modulo 2^CNT_W.
- LOCK_N, 2: consecutive matching samples needed to reach LOCKED; range 1..7.
- ERR_W, 4: width of the saturating error tally.
- WRAP_W, 8: width of the saturating wrap tally.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset. Asserting it (0) immediately forces all state to reset values. Release is synchronised externally.
- in_val, input, 1: sample qualifier; `in_` is consumed only on cycles with in_val=1.
- in_, input, CNT_W: count value from the upstream counter.
- clear, input, 1: synchronous clear of err_count and wrap_count only.
- locked, output, 1: registered; 1 while the FSM is in LOCKED.
- err, output, 1: registered one-cycle pulse, asserted the cycle after a mismatching sample is accepted in LOCKED.
- wrap, output, 1: registered one-cycle pulse, asserted the cycle after a matching sample equal to 0 is accepted in LOCKED.
- err_count, output, ERR_W: saturating mismatch tally.
- wrap_count, output, WRAP_W: saturating wrap tally.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, expected=0, match_cnt=0.
  - locked=0, err=0, wrap=0, err_count=0, wrap_count=0.
- Internal registers:
  - expected (CNT_W): next value predicted.
  - match_cnt (3b): consecutive matches counted during ACQ.
- Prediction arithmetic: expected <= in_ + 1, truncated to CNT_W, so 7 -> 0.
- Cycles with in_val=0: state, expected and match_cnt hold; err and wrap are 0.
- IDLE, on in_val=1:
  - expected <= in_+1, match_cnt <= 0, state <= ACQ.
  - No err is reported.
- ACQ, on in_val=1 with in_==expected:
  - expected <= in_+1.
  - If match_cnt+1 == LOCK_N: state <= LOCKED. Otherwise match_cnt <= match_cnt+1.
- ACQ, on in_val=1 with in_!=expected:
  - Silent resync: expected <= in_+1, match_cnt <= 0, stay in ACQ.
  - No err is reported.
- LOCKED, on in_val=1 with in_==expected:
  - expected <= in_+1.
  - If in_==0: wrap pulse next cycle and wrap_count increments.
- LOCKED, on in_val=1 with in_!=expected:
  - err pulse next cycle and err_count increments.
  - expected <= in_+1, match_cnt <= 0, state <= ACQ; locked drops next cycle.
- Latency:
  - locked rises one cycle after the LOCK_N-th matching sample is accepted.
  - err and wrap pulse exactly one cycle after the triggering sample.
- Saturation: err_count stops at 2^ERR_W-1 and wrap_count stops at 2^WRAP_W-1. The err and wrap pulses still fire when the counts are saturated.
- clear:
  - Zeroes both counts next cycle.
  - If clear coincides with an increment event, clear wins: count=0. The err/wrap pulse is still issued.
  - clear does not affect the FSM or the pulses.
- LOCK_N=1: the first matching sample in ACQ moves the FSM to LOCKED.
- A wrap sample (in_==0) seen outside LOCKED is never counted.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous), and any pending pulse is dropped.

Decomposition:
- Shared package seq_count_monitor_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACQ, LOCKED} mon_state_t.
  - Default width constants CNT_W_DFLT=3, ERR_W_DFLT=4, WRAP_W_DFLT=8.
- One natural sub-module, sat_counter:
  - Parameter W.
  - Ports clk, reset (async active-low), clear, inc, count.
  - clear has priority over inc; the count holds at its maximum value.
  - Instantiated twice, for err_count and wrap_count.
- FSM and prediction logic stay in the top module.

Test Plan:
- Lock acquisition: after reset, feed valid samples 3,4,5 on consecutive cycles. locked=0 through the cycle after 4, locked=1 the cycle after 5, err_count=0.
- Wrap: once locked, feed 6,7,0,1. A single wrap pulse occurs the cycle after 0, wrap_count=1, err never asserts.
- Mismatch: locked at expected=2, feed 5. Next cycle err=1, err_count=1, locked=0. Then feed 6,7: locked=1 the cycle after 7 (LOCK_N=2).
- Valid gaps: locked, feed 2, then in_val=0 for 3 cycles with in_ driven to 5, then valid 3. No err, locked stays 1.
- Saturation and clear:
  - Force 20 mismatch events (alternating re-lock and bad sample): err_count sticks at 15 and err pulses 20 times.
  - Assert clear on the same cycle as the 21st increment: err_count=0 the next cycle.
- Async reset: locked with wrap_count=3, drive reset=0 mid-cycle. All outputs read 0 before the next clk edge. After release, a sample of 0 leaves the FSM in ACQ with no wrap.

Source files
------------

// File: rtl/seq_count_monitor_pkg.sv
// Shared types and default widths for the counter-stream monitor.
package seq_count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } mon_state_t;

    localparam int unsigned CNT_W_DFLT  = 3;
    localparam int unsigned ERR_W_DFLT  = 4;
    localparam int unsigned WRAP_W_DFLT = 8;

endpackage : seq_count_monitor_pkg

// File: rtl/sat_counter.sv
// Saturating event tally with synchronous clear.
//   clk   : clock
//   reset : asynchronous active-low reset
//   clear : zero the tally next cycle (wins over inc)
//   inc   : add one unless already at the maximum
//   count : current tally
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE = W'(1);

    // Tally register; holds once it reaches MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule : sat_counter

// File: rtl/seq_count_3b_monitor.sv
// Checks that a valid-qualified counter stream increments by one (mod 2^CNT_W).
//   clk        : clock
//   reset      : asynchronous active-low reset
//   in_val     : sample qualifier for in_
//   in_        : observed count value
//   clear      : synchronous clear of err_count and wrap_count
//   locked     : FSM is in LOCKED
//   err        : one-cycle pulse after a mismatch accepted while locked
//   wrap       : one-cycle pulse after a matching zero accepted while locked
//   err_count  : saturating mismatch tally
//   wrap_count : saturating wrap tally
module seq_count_3b_monitor
    import seq_count_monitor_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DFLT,
    parameter int unsigned LOCK_N = 2,
    parameter int unsigned ERR_W  = ERR_W_DFLT,
    parameter int unsigned WRAP_W = WRAP_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    input  logic [CNT_W-1:0]  in_,
    input  logic              clear,
    output logic              locked,
    output logic              err,
    output logic              wrap,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       MATCH_ONE = 3'(1);
    // match_cnt value at which the next match completes acquisition.
    localparam logic [2:0]       LOCK_LAST = 3'(LOCK_N - 1);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] expected_q, expected_d;
    logic [2:0]       match_cnt_q, match_cnt_d;
    logic             err_d, wrap_d;
    logic             hit_c;
    logic [CNT_W-1:0] next_pred_c;

    assign hit_c       = (in_ == expected_q);
    assign next_pred_c = in_ + CNT_ONE;

    // State, prediction and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            match_cnt_q <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            locked      <= (state_d == LOCKED);
            err         <= err_d;
            wrap        <= wrap_d;
        end
    end

    // Next-state and pulse decode; nothing moves without in_val.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        if (in_val) begin
            // Every accepted sample reseeds the prediction.
            expected_d = next_pred_c;
            unique case (state_q)
                IDLE: begin
                    match_cnt_d = '0;
                    state_d     = ACQ;
                end
                ACQ: begin
                    if (!hit_c) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q == LOCK_LAST) begin
                        state_d = LOCKED;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_ONE;
                    end
                end
                LOCKED: begin
                    if (hit_c) begin
                        wrap_d = (in_ == '0);
                    end else begin
                        err_d       = 1'b1;
                        match_cnt_d = '0;
                        state_d     = ACQ;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    match_cnt_d = '0;
                end
            endcase
        end
    end

    // Tallies advance on the same edge that launches the matching pulse.
    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (err_d),
        .count (err_count)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (wrap_d),
        .count (wrap_count)
    );

endmodule : seq_count_3b_monitor

// File: tb/tb_seq_count_3b_monitor.sv
// Directed bench for seq_count_3b_monitor with a streak-based reference model.
module tb_seq_count_3b_monitor;

    localparam int LOCK_N   = 2;
    localparam int ERR_MAX  = 15;
    localparam int WRAP_MAX = 255;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic [2:0] in_;
    logic       clear;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [3:0] err_count;
    logic [7:0] wrap_count;

    int n_cmp;
    int n_fail;

    seq_count_3b_monitor #(
        .CNT_W  (3),
        .LOCK_N (LOCK_N),
        .ERR_W  (4),
        .WRAP_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in_        (in_),
        .clear      (clear),
        .locked     (locked),
        .err        (err),
        .wrap       (wrap),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: length of the current run of +1 samples; locked once
    // the run holds more than LOCK_N samples (seed plus LOCK_N matches).
    int         m_streak;
    logic [2:0] m_last;
    logic       m_err;
    logic       m_wrap;
    int         m_errc;
    int         m_wrapc;
    logic       m_locked;

    logic       follows_c;
    logic       was_locked_c;
    logic       ev_err_c;
    logic       ev_wrap_c;
    int         nxt_streak_c;
    logic [2:0] last_inc_c;

    assign m_locked = (m_streak > LOCK_N);

    always_comb begin
        last_inc_c   = m_last + 3'd1;
        follows_c    = (m_streak > 0) && (in_ == last_inc_c);
        was_locked_c = (m_streak > LOCK_N);
        nxt_streak_c = 1;
        if (follows_c) nxt_streak_c = (m_streak < 100) ? m_streak + 1 : m_streak;
        ev_err_c  = in_val && was_locked_c && !follows_c;
        ev_wrap_c = in_val && was_locked_c && follows_c && (in_ == 3'd0);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_streak <= 0;
            m_last   <= 3'd0;
            m_err    <= 1'b0;
            m_wrap   <= 1'b0;
            m_errc   <= 0;
            m_wrapc  <= 0;
        end else begin
            if (in_val) begin
                m_streak <= nxt_streak_c;
                m_last   <= in_;
            end
            m_err  <= ev_err_c;
            m_wrap <= ev_wrap_c;
            if (clear)                          m_errc <= 0;
            else if (ev_err_c && m_errc < ERR_MAX) m_errc <= m_errc + 1;
            if (clear)                             m_wrapc <= 0;
            else if (ev_wrap_c && m_wrapc < WRAP_MAX) m_wrapc <= m_wrapc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("cyc_locked",     int'(locked),     int'(m_locked));
        check("cyc_err",        int'(err),        int'(m_err));
        check("cyc_wrap",       int'(wrap),       int'(m_wrap));
        check("cyc_err_count",  int'(err_count),  m_errc);
        check("cyc_wrap_count", int'(wrap_count), m_wrapc);
    endtask

    // Drive one cycle of inputs at the falling edge, return at the next one.
    task automatic step(input logic v, input logic [2:0] d, input logic c);
        in_val = v;
        in_    = d;
        clear  = c;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] e;
        logic [2:0] bad;
        int         err_pulses;
        int         zeros;

        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        in_val = 1'b0;
        in_    = 3'd0;
        clear  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        repeat (2) @(negedge clk);
        check("rst_locked", int'(locked), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_wrap_count", int'(wrap_count), 0);
        reset = 1'b1;
        step(1'b0, 3'd0, 1'b0);

        // Lock acquisition.
        step(1'b1, 3'd3, 1'b0);
        check("acq_after3", int'(locked), 0);
        step(1'b1, 3'd4, 1'b0);
        check("acq_after4", int'(locked), 0);
        step(1'b1, 3'd5, 1'b0);
        check("acq_after5", int'(locked), 1);
        check("model_lock", int'(m_locked), 1);
        check("acq_errcnt", int'(err_count), 0);

        // Wrap while locked.
        step(1'b1, 3'd6, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        check("wrap_before", int'(wrap), 0);
        step(1'b1, 3'd0, 1'b0);
        check("wrap_pulse", int'(wrap), 1);
        check("wrap_cnt1", int'(wrap_count), 1);
        step(1'b1, 3'd1, 1'b0);
        check("wrap_single", int'(wrap), 0);
        check("wrap_no_err", int'(err), 0);

        // Mismatch at expected=2.
        step(1'b1, 3'd5, 1'b0);
        check("mm_err", int'(err), 1);
        check("mm_errcnt", int'(err_count), 1);
        check("mm_unlock", int'(locked), 0);
        check("model_err", int'(m_err), 1);
        step(1'b1, 3'd6, 1'b0);
        check("mm_after6", int'(locked), 0);
        check("mm_err_once", int'(err), 0);
        step(1'b1, 3'd7, 1'b0);
        check("mm_relock", int'(locked), 1);

        // Valid gaps with junk data.
        step(1'b1, 3'd0, 1'b0);
        check("gap_wrapcnt", int'(wrap_count), 2);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        repeat (3) step(1'b0, 3'd5, 1'b0);
        check("gap_locked", int'(locked), 1);
        step(1'b1, 3'd3, 1'b0);
        check("gap_no_err", int'(err), 0);
        check("gap_still_locked", int'(locked), 1);

        // Twenty mismatch events, then a clear racing the 21st.
        e          = 3'd4;
        err_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bad = e + 3'd3;
            step(1'b1, bad, 1'b0);
            if (err) err_pulses++;
            step(1'b1, bad + 3'd1, 1'b0);
            step(1'b1, bad + 3'd2, 1'b0);
            e = bad + 3'd3;
        end
        check("sat_pulses", err_pulses, 20);
        check("sat_errcnt", int'(err_count), 15);
        check("sat_locked", int'(locked), 1);
        bad = e + 3'd3;
        step(1'b1, bad, 1'b1);
        check("clr_err_pulse", int'(err), 1);
        check("clr_errcnt", int'(err_count), 0);
        check("clr_wrapcnt", int'(wrap_count), 0);
        step(1'b1, bad + 3'd1, 1'b0);
        step(1'b1, bad + 3'd2, 1'b0);
        e = bad + 3'd3;
        check("clr_relock", int'(locked), 1);

        // Run until the third wrap, ending on the zero sample.
        zeros = 0;
        for (int i = 0; i < 40 && zeros < 3; i++) begin
            step(1'b1, e, 1'b0);
            if (e == 3'd0) zeros++;
            e = e + 3'd1;
        end
        check("pre_rst_wrapcnt", int'(wrap_count), 3);
        check("pre_rst_wrap", int'(wrap), 1);

        // Asynchronous reset mid-cycle drops everything, including the pulse.
        in_val = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_locked", int'(locked), 0);
        check("arst_wrap", int'(wrap), 0);
        check("arst_err", int'(err), 0);
        check("arst_errcnt", int'(err_count), 0);
        check("arst_wrapcnt", int'(wrap_count), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 3'd0, 1'b0);
        check("post_rst_locked", int'(locked), 0);
        check("post_rst_wrap", int'(wrap), 0);
        check("post_rst_wrapcnt", int'(wrap_count), 0);
        step(1'b1, 3'd1, 1'b0);
        check("post_rst_acq", int'(locked), 0);
        step(1'b0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seq_count_3b_monitor
